// File: rtl/bsg_rf_pkg.sv
// Shared types and helpers for the bsg_rf register file family.
package bsg_rf_pkg;

  typedef enum logic {eInit, eReady} state_e;

  localparam int byte_width_gp      = 8;
  localparam int merge_max_width_gp = 512;
  localparam int merge_max_mask_gp  = merge_max_width_gp / byte_width_gp;

  // Bytes with mask=1 come from new_word, the rest from old_word.
  function automatic logic [merge_max_width_gp-1:0] masked_merge(
    input logic [merge_max_width_gp-1:0] old_word,
    input logic [merge_max_width_gp-1:0] new_word,
    input logic [merge_max_mask_gp-1:0]  mask
  );
    logic [merge_max_width_gp-1:0] result;
    result = old_word;
    for (int b = 0; b < merge_max_mask_gp; b++) begin
      if (mask[b]) result[b*byte_width_gp +: byte_width_gp] = new_word[b*byte_width_gp +: byte_width_gp];
    end
    return result;
  endfunction

endpackage

// File: rtl/bsg_rf_bypass_merge.sv
// Combinational byte-mask merge of a stored word with incoming write data.
module bsg_rf_bypass_merge
  import bsg_rf_pkg::*;
#(
  parameter  int width_p       = 32,
  localparam int mask_width_lp = width_p / byte_width_gp
) (
  input  logic [width_p-1:0]       old_i,
  input  logic [width_p-1:0]       new_i,
  input  logic [mask_width_lp-1:0] mask_i,
  output logic [width_p-1:0]       merged_o
);

  assign merged_o = width_p'(masked_merge(merge_max_width_gp'(old_i),
                                          merge_max_width_gp'(new_i),
                                          merge_max_mask_gp'(mask_i)));

endmodule

// File: rtl/bsg_rf_mr1w_sync_init.sv
// Multi-read, single-write register file that sweeps itself to zero after every reset.
// Optional macro BSG_RF_WRITE_FIRST_BYPASS_EN: same-cycle read of the written entry returns the merged new word.
//
// state  | meaning
// eInit  | zeroing entry[cnt_r] each edge; all ports ignored, read data held at 0
// eReady | normal operation: one masked write and read_ports_p reads per cycle
module bsg_rf_mr1w_sync_init
  import bsg_rf_pkg::*;
#(
  parameter  int width_p       = 32,
  parameter  int els_p         = 32,
  parameter  int read_ports_p  = 2,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / byte_width_gp
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  output logic                                  ready_o,
  input  logic                                  w_v_i,
  input  logic [addr_width_lp-1:0]              w_addr_i,
  input  logic [mask_width_lp-1:0]              w_mask_i,
  input  logic [width_p-1:0]                    w_data_i,
  input  logic [read_ports_p-1:0]               r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
  output logic [read_ports_p*width_p-1:0]       r_data_o
);

  localparam logic [addr_width_lp:0] els_lp  = (addr_width_lp+1)'(els_p);
  localparam logic [addr_width_lp:0] last_lp = (addr_width_lp+1)'(els_p - 1);
  localparam logic [addr_width_lp:0] one_lp  = (addr_width_lp+1)'(1);

  state_e                   state_r, state_n;
  logic [addr_width_lp:0]   cnt_r, cnt_n;
  logic [width_p-1:0]       mem_r [els_p];
  logic [addr_width_lp-1:0] init_addr;
  logic                     w_addr_ok;
  logic                     w_en;
  logic [width_p-1:0]       w_merged;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eInit;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (state_r == eInit) begin
      cnt_n = cnt_r + one_lp;
      if (cnt_r == last_lp) state_n = eReady;
    end
  end

  assign ready_o   = (state_r == eReady);
  assign init_addr = cnt_r[addr_width_lp-1:0];
  assign w_addr_ok = ({1'b0, w_addr_i} < els_lp);
  assign w_en      = ready_o & w_v_i & w_addr_ok;

  bsg_rf_bypass_merge #(.width_p(width_p)) wmerge (
    .old_i    (mem_r[w_addr_i]),
    .new_i    (w_data_i),
    .mask_i   (w_mask_i),
    .merged_o (w_merged)
  );

  // Storage is not reset; the init sweep clears it. Held reset blocks any write.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_r == eInit) mem_r[init_addr] <= '0;
      else if (w_en)        mem_r[w_addr_i]  <= w_merged;
    end
  end

  for (genvar p = 0; p < read_ports_p; p++) begin : rp
    logic [addr_width_lp-1:0] addr;
    logic                     addr_ok;
    logic [width_p-1:0]       rd_word;
    logic [width_p-1:0]       data_r;

    assign addr    = r_addr_i[p*addr_width_lp +: addr_width_lp];
    assign addr_ok = ({1'b0, addr} < els_lp);

`ifdef BSG_RF_WRITE_FIRST_BYPASS_EN
    logic hit;
    assign hit = w_en && (w_addr_i == addr);

    bsg_rf_bypass_merge #(.width_p(width_p)) rmerge (
      .old_i    (mem_r[addr]),
      .new_i    (w_data_i),
      .mask_i   (hit ? w_mask_i : '0),
      .merged_o (rd_word)
    );
`else
    assign rd_word = mem_r[addr];
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                data_r <= '0;
      else if (state_r == eInit)  data_r <= '0;
      else if (r_v_i[p])          data_r <= addr_ok ? rd_word : '0;
    end

    assign r_data_o[p*width_p +: width_p] = data_r;
  end

endmodule

// File: tb/tb_bsg_rf_mr1w_sync_init.sv
// Bench for bsg_rf_mr1w_sync_init: a 32x32 2-read instance and a 24x16 1-read instance
// checked against an array-based reference model.
module tb_bsg_rf_mr1w_sync_init;

  localparam int els1 = 32;
  localparam int els2 = 24;
`ifdef BSG_RF_WRITE_FIRST_BYPASS_EN
  localparam bit bypass_c = 1'b1;
`else
  localparam bit bypass_c = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        ready;
  logic        w_v;
  logic [4:0]  w_addr;
  logic [3:0]  w_mask;
  logic [31:0] w_data;
  logic [1:0]  r_v;
  logic [9:0]  r_addr;
  logic [63:0] r_data;

  logic        ready2;
  logic        w2_v;
  logic [4:0]  w2_addr;
  logic [1:0]  w2_mask;
  logic [15:0] w2_data;
  logic [0:0]  r2_v;
  logic [4:0]  r2_addr;
  logic [15:0] r2_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m  [els1];
  logic [31:0] exp_rd [2];
  logic [15:0] mem2_m [els2];
  logic [15:0] exp_rd2;
  int          edges;

  bsg_rf_mr1w_sync_init #(.width_p(32), .els_p(els1), .read_ports_p(2)) dut (
    .clk_i(clk), .reset_i(reset), .ready_o(ready),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_mask_i(w_mask), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(r_data)
  );

  bsg_rf_mr1w_sync_init #(.width_p(16), .els_p(els2), .read_ports_p(1)) dut2 (
    .clk_i(clk), .reset_i(reset), .ready_o(ready2),
    .w_v_i(w2_v), .w_addr_i(w2_addr), .w_mask_i(w2_mask), .w_data_i(w2_data),
    .r_v_i(r2_v), .r_addr_i(r2_addr), .r_data_o(r2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] m);
    logic [15:0] r;
    r = o;
    for (int b = 0; b < 2; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic idle();
    w_v = 0; w_addr = '0; w_mask = '0; w_data = '0; r_v = '0; r_addr = '0;
    w2_v = 0; w2_addr = '0; w2_mask = '0; w2_data = '0; r2_v = '0; r2_addr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    w_v = 1; w_addr = a; w_data = d; w_mask = m;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    r_v[p] = 1'b1;
    r_addr[p*5 +: 5] = a;
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    foreach (mem2_m[i]) mem2_m[i] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_rd2 = '0;
    edges = 0;
  endtask

  // One clock: predict from current inputs, let the edge pass, compare on the falling edge.
  task automatic step(input string tag);
    logic [31:0] nxt [2];
    logic [15:0] nxt2;
    logic [4:0]  a;
    bit          rdy, rdy2;
    rdy  = (edges >= els1);
    rdy2 = (edges >= els2);
    for (int p = 0; p < 2; p++) begin
      nxt[p] = exp_rd[p];
      a = r_addr[p*5 +: 5];
      if (rdy && r_v[p]) begin
        if (int'(a) >= els1) nxt[p] = '0;
        else if (bypass_c && w_v && w_addr == a) nxt[p] = merge32(mem_m[a], w_data, w_mask);
        else nxt[p] = mem_m[a];
      end
    end
    if (rdy && w_v && int'(w_addr) < els1) mem_m[w_addr] = merge32(mem_m[w_addr], w_data, w_mask);
    nxt2 = exp_rd2;
    if (rdy2 && r2_v[0]) begin
      if (int'(r2_addr) >= els2) nxt2 = '0;
      else if (bypass_c && w2_v && w2_addr == r2_addr) nxt2 = merge16(mem2_m[r2_addr], w2_data, w2_mask);
      else nxt2 = mem2_m[r2_addr];
    end
    if (rdy2 && w2_v && int'(w2_addr) < els2) mem2_m[w2_addr] = merge16(mem2_m[w2_addr], w2_data, w2_mask);
    @(negedge clk);
    edges++;
    exp_rd[0] = nxt[0]; exp_rd[1] = nxt[1]; exp_rd2 = nxt2;
    check({tag, "_ready"},  64'(ready),  64'(edges >= els1));
    check({tag, "_ready2"}, 64'(ready2), 64'(edges >= els2));
    check({tag, "_rd0"}, 64'(r_data[31:0]),  64'(exp_rd[0]));
    check({tag, "_rd1"}, 64'(r_data[63:32]), 64'(exp_rd[1]));
    check({tag, "_rd2"}, 64'(r2_data),       64'(exp_rd2));
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    check("reset_ready",  64'(ready),  64'(0));
    check("reset_ready2", 64'(ready2), 64'(0));
    check("reset_rdata",  r_data,      64'(0));
    reset = 1'b0;

    // Init sweep: inputs are ignored while it runs.
    for (int i = 0; i < els1; i++) begin
      idle();
      wr(5'(i), 32'hDEAD_BEEF, 4'hF);
      rd(0, 5'(i));
      step("init");
    end

    for (int i = 0; i < els1; i++) begin
      idle(); rd(0, 5'(i)); rd(1, 5'(31 - i));
      step("zero");
    end

    idle(); wr(5, 32'hAABB_CCDD, 4'b1111); step("mask_a");
    idle(); wr(5, 32'h1122_3344, 4'b0101); step("mask_b");
    idle(); rd(0, 5); step("mask_rd");
    check("mask_const", 64'(r_data[31:0]), 64'h0000_0000_AA22_CC44);
    idle(); wr(5, 32'h0, 4'b0000); step("mask_zero");
    idle(); rd(1, 5); step("mask_zero_rd");
    check("mask_zero_const", 64'(r_data[63:32]), 64'h0000_0000_AA22_CC44);

    idle(); wr(3, 32'h3, 4'hF); step("mp_w3");
    idle(); wr(7, 32'h7, 4'hF); step("mp_w7");
    idle(); rd(0, 3); rd(1, 7); step("mp_rd");
    check("mp_const", r_data, 64'h0000_0007_0000_0003);
    for (int i = 0; i < 3; i++) begin idle(); wr(3, 32'h5555_5555, 4'hF); step("mp_hold"); end
    check("mp_hold_const", r_data, 64'h0000_0007_0000_0003);

    idle(); wr(9, 32'hFFFF_FFFF, 4'hF); step("col_init");
    idle(); wr(9, 32'h0, 4'b0011); rd(0, 9); rd(1, 9); step("col");
    check("col_const", r_data, bypass_c ? 64'hFFFF_0000_FFFF_0000 : 64'hFFFF_FFFF_FFFF_FFFF);
    idle(); rd(0, 9); rd(1, 9); step("col_after");
    check("col_after_const", r_data, 64'hFFFF_0000_FFFF_0000);

    idle(); w2_v = 1; w2_addr = 30; w2_data = 16'hBEEF; w2_mask = 2'b11; step("np2_w30");
    idle(); r2_v = 1; r2_addr = 30; step("np2_r30");
    check("np2_r30_const", 64'(r2_data), 64'(0));
    idle(); r2_v = 1; r2_addr = 6; step("np2_r6");
    idle(); w2_v = 1; w2_addr = 23; w2_data = 16'h1234; w2_mask = 2'b11; step("np2_w23");
    idle(); r2_v = 1; r2_addr = 23; step("np2_r23");
    check("np2_r23_const", 64'(r2_data), 64'h1234);

    for (int i = 0; i < 400; i++) begin
      idle();
      w_v = 1'($urandom); w_addr = 5'($urandom); w_mask = 4'($urandom); w_data = $urandom;
      r_v = 2'($urandom); r_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) r_addr[4:0] = w_addr;
      if ($urandom_range(0, 3) == 0) r_addr[9:5] = w_addr;
      w2_v = 1'($urandom); w2_addr = 5'($urandom); w2_mask = 2'($urandom); w2_data = 16'($urandom);
      r2_v = 1'($urandom); r2_addr = ($urandom_range(0, 2) == 0) ? w2_addr : 5'($urandom);
      step("rand");
    end

    for (int i = 0; i < els1; i++) begin
      idle(); wr(5'(i), 32'(i + 1) * 32'h0101_0101, 4'hF); step("fill");
    end
    idle(); rd(0, 0); rd(1, 31); r2_v = 1; r2_addr = 23; step("pre_rst");
    idle();
    #2 reset = 1'b1;
    #1;
    check("midrst_ready",  64'(ready),  64'(0));
    check("midrst_ready2", 64'(ready2), 64'(0));
    check("midrst_rdata",  r_data,      64'(0));
    check("midrst_rdata2", 64'(r2_data), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < els1; i++) begin idle(); step("reinit"); end
    for (int i = 0; i < els1; i++) begin
      idle(); rd(0, 5'(i)); rd(1, 5'(31 - i)); r2_v = 1; r2_addr = 5'(i);
      step("rezero");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_rf_mr1w_sync_init.md
Name: bsg_rf_mr1w_sync_init

Overview:
- Parametrised multi-read-port, single-write-port synchronous register file for vanilla-core-class pipelines.
- Successor to the fixed 32x32 1R1W macro box: generalises width, depth and read-port count, and adds per-byte write masks.
- Adds write-to-read bypass and a self-clearing init sequencer, so contents are zero after every reset.
- Behavioural storage (flops/synth array); no hard-macro test/DFT pins.

Parameters:
- width_p, 32, data word width; must be a multiple of 8
- els_p, 32, number of entries; must be >= 2
- read_ports_p, 2, number of independent read ports; must be >= 1
- addr_width_lp, $clog2(els_p), derived address width; not overridable
- mask_width_lp, width_p/8, derived byte-mask width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  asynchronous, active-high reset
- ready_o  out  1  high once the init sweep is complete; reads and writes are accepted only when high
- w_v_i  in  1  write valid
- w_addr_i  in  addr_width_lp  write address
- w_mask_i  in  mask_width_lp  byte write enables; bit b covers data bits [8b+7:8b]
- w_data_i  in  width_p  write data
- r_v_i  in  read_ports_p  per-port read valid
- r_addr_i  in  read_ports_p*addr_width_lp  packed read addresses; port p occupies slice p
- r_data_o  out  read_ports_p*width_p  packed registered read data; port p occupies slice p

Behaviour:
- States: eInit, eReady. Init counter is addr_width_lp+1 bits wide.
- Reset asserted (async) -> state eInit, counter 0, ready_o=0, all r_data_o=0. Memory contents are not reset directly.
- eInit:
  - Each rising edge writes all-zero to entry[counter], then counter increments.
  - On the edge that writes entry els_p-1, state moves to eReady.
  - ready_o=1 from the cycle after that edge: exactly els_p edges after reset deasserts.
  - All w_*/r_* inputs are ignored; r_data_o holds 0.
- eReady writes:
  - w_v_i=1 and w_addr_i<els_p -> at the edge, bytes with mask bit 1 are updated; other bytes are kept.
  - Mask all-zero -> no change.
  - w_addr_i>=els_p (non-power-of-2 depth) -> write dropped.
- eReady reads:
  - r_v_i[p]=1 -> r_data_o[p] updated at the edge, valid the following cycle (1-cycle latency).
  - r_v_i[p]=0 -> r_data_o[p] holds its previous value indefinitely.
  - r_addr_i>=els_p -> r_data_o[p] becomes 0.
- Same-cycle read/write to the same address (bypass): port returns the merged word (new bytes where mask=1, old bytes elsewhere). Write-first semantics.
- Multiple ports may read the same address in the same cycle. Each returns an identical value, including bypass.
- Reset mid-operation (either state) -> immediate return to eInit. The sweep restarts at entry 0 and ready_o drops asynchronously. Any in-flight write on the reset edge is discarded.
- No stall/backpressure once in eReady: one write and read_ports_p reads per cycle, every cycle.

Optional Feature:
- Macro: BSG_RF_WRITE_FIRST_BYPASS_EN.
- Defined: same-address read/write collision returns merged new data, as above.
- Undefined: collision returns the old stored word (read-first). No bypass mux is instantiated; the write still takes effect for subsequent reads.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package bsg_rf_pkg contains:
  - the state enum (eInit, eReady)
  - the byte width constant (8)
  - a function computing the masked merge of old/new words
- Sub-module bsg_rf_bypass_merge: combinational byte-mask merge of a stored word with write data.
  - Used by the write path always.
  - Used per read port only when BSG_RF_WRITE_FIRST_BYPASS_EN is defined.

Test Plan:
- Init timing: release reset with els_p=32 -> ready_o=0 for 32 edges, then 1. Reading all 32 entries returns 0x00000000.
- Byte mask: write addr 5 data 0xAABBCCDD mask 4'b1111, then addr 5 data 0x11223344 mask 4'b0101. Read addr 5 -> 0xAA22CC44.
- Multi-port read: ports 0/1 read addr 3/7 (holding 0x3, 0x7) in the same cycle -> next cycle r_data_o slices = 0x3 and 0x7. Holding r_v_i=0 keeps both values.
- Collision: addr 9 holds 0xFFFFFFFF; write 0x00000000 mask 4'b0011 while both ports read addr 9.
  - With macro defined: both ports return 0xFFFF0000.
  - With macro undefined: both ports return 0xFFFFFFFF; the next read returns 0xFFFF0000.
- Mid-op reset: write entries 0..31 nonzero, assert reset for 1 cycle -> ready_o drops immediately, r_data_o=0. After 32 edges, all reads return 0.
- Non-power-of-2: els_p=24, width_p=16. Write addr 30 is dropped; read addr 30 returns 0x0000; init completes in 24 edges.
